iir_stream_ctrl: RTL and testbench

Sequencer that runs one filtering job through the 2nd-order IIR_filter datapath.
- Clears the filter state before each job.
- Streams a programmed number of Q2.6 samples in from a valid/ready source, feeding the filter one sample per clock.
- Flushes the pipeline and aligns Q2.15 results onto a valid-tagged output with a last marker and completion status.
- Sits between the sample source (ADC/capture buffer) and the IIR_filter instance, which it drives directly.

---
 rtl/iir_stream_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_iir_stream_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_stream_ctrl.sv
// iir_stream_ctrl: runs one filtering job through a 2nd-order IIR datapath.
// Clears the filter, streams a programmed number of Q2.6 samples from a
// valid/ready source (zero-stuffing on starvation), flushes the pipeline and
// presents tagged Q2.15 results with a last marker and completion pulse.
module iir_stream_ctrl #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 17,
    parameter int LATENCY    = 1,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    input  logic             s_valid,
    input  logic [IN_W-1:0]  s_data,
    output logic             s_ready,
    output logic             flt_reset_n,
    output logic [IN_W-1:0]  flt_data_in,
    input  logic [OUT_W-1:0] flt_data_out,
    output logic             m_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last
);

    localparam int CLR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [LATENCY:0]   tag_q, tag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;
    logic               s_ready_q, s_ready_d;
    logic               flt_reset_n_q, flt_reset_n_d;
    logic [IN_W-1:0]    flt_data_in_q, flt_data_in_d;
    logic               m_valid_q, m_valid_d;
    logic [OUT_W-1:0]   m_data_q, m_data_d;
    logic               m_last_q, m_last_d;

    logic start_ok_s;
    logic start_zero_s;
    logic run_hs_s;
    logic clr_end_s;
    logic tag_empty_s;

    // Decode of the conditions that steer the sequencer.
    always_comb begin
        start_ok_s   = (state_q == ST_IDLE) && start && (num_samples != {CNT_W{1'b0}});
        start_zero_s = (state_q == ST_IDLE) && start && (num_samples == {CNT_W{1'b0}});
        run_hs_s     = (state_q == ST_RUN) && s_valid && s_ready_q;
        clr_end_s    = (clr_cnt_q == CLR_W'(RST_CYCLES - 1));
        tag_empty_s  = (tag_q == {(LATENCY + 1){1'b0}});
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_CLEAR;
                else            state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_end_s) state_d = ST_RUN;
                else           state_d = ST_CLEAR;
            end
            ST_RUN: begin
                if (run_hs_s && (remaining_q == CNT_W'(1))) state_d = ST_FLUSH;
                else                                        state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if (tag_empty_s) state_d = ST_FIN;
                else             state_d = ST_FLUSH;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; every output is registered from these.
    always_comb begin
        clr_cnt_d = (state_q == ST_CLEAR) ? (clr_cnt_q + CLR_W'(1)) : {CLR_W{1'b0}};

        if (start_ok_s) begin
            remaining_d = num_samples;
            count_d     = num_samples;
            out_cnt_d   = {CNT_W{1'b0}};
            underrun_d  = 1'b0;
        end else begin
            remaining_d = run_hs_s ? (remaining_q - CNT_W'(1)) : remaining_q;
            count_d     = count_q;
            out_cnt_d   = tag_q[LATENCY] ? (out_cnt_q + CNT_W'(1)) : out_cnt_q;
            underrun_d  = ((state_q == ST_RUN) && !run_hs_s) ? 1'b1 : underrun_q;
        end

        // A starved RUN cycle still advances the filter, on a zero that carries no tag.
        tag_d         = {tag_q[LATENCY-1:0], run_hs_s};
        flt_data_in_d = run_hs_s ? s_data : {IN_W{1'b0}};

        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_FIN) || start_zero_s;
        s_ready_d     = (state_d == ST_RUN);
        flt_reset_n_d = (state_d != ST_CLEAR);

        m_valid_d = tag_q[LATENCY];
        m_data_d  = tag_q[LATENCY] ? flt_data_out : m_data_q;
        m_last_d  = tag_q[LATENCY] && ((out_cnt_q + CNT_W'(1)) == count_q);
    end

    // Registers for counters, tag pipe and all outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q     <= {CLR_W{1'b0}};
            remaining_q   <= {CNT_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            out_cnt_q     <= {CNT_W{1'b0}};
            tag_q         <= {(LATENCY + 1){1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            underrun_q    <= 1'b0;
            s_ready_q     <= 1'b0;
            flt_reset_n_q <= 1'b1;
            flt_data_in_q <= {IN_W{1'b0}};
            m_valid_q     <= 1'b0;
            m_data_q      <= {OUT_W{1'b0}};
            m_last_q      <= 1'b0;
        end else begin
            clr_cnt_q     <= clr_cnt_d;
            remaining_q   <= remaining_d;
            count_q       <= count_d;
            out_cnt_q     <= out_cnt_d;
            tag_q         <= tag_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            underrun_q    <= underrun_d;
            s_ready_q     <= s_ready_d;
            flt_reset_n_q <= flt_reset_n_d;
            flt_data_in_q <= flt_data_in_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign underrun    = underrun_q;
    assign s_ready     = s_ready_q;
    assign flt_reset_n = flt_reset_n_q;
    assign flt_data_in = flt_data_in_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;

endmodule

// File: tb/tb_iir_stream_ctrl.sv
// Testbench for iir_stream_ctrl: a simple one-pole filter stands in for the
// IIR datapath (y = (x << 9) + (y >>> 1), one clock of latency, cleared by
// flt_reset_n). Expected results are hand-computed and queued per job; a
// negedge monitor pops and compares whenever m_valid is high.
module tb_iir_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = 16'h0000;
    logic        busy, done, underrun;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        flt_reset_n;
    logic [7:0]  flt_data_in;
    logic [16:0] flt_data_out;
    logic        m_valid;
    logic [16:0] m_data;
    logic        m_last;

    iir_stream_ctrl #(
        .IN_W(8), .OUT_W(17), .LATENCY(1), .RST_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_samples(num_samples),
        .busy(busy), .done(done), .underrun(underrun),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .flt_reset_n(flt_reset_n), .flt_data_in(flt_data_in), .flt_data_out(flt_data_out),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Stand-in filter with state, so a missing CLEAR shows up in the results.
    logic signed [16:0] flt_y;
    always @(posedge clk or negedge flt_reset_n) begin
        if (!flt_reset_n) flt_y <= 17'sd0;
        else              flt_y <= ($signed({{9{flt_data_in[7]}}, flt_data_in}) <<< 9) + (flt_y >>> 1);
    end
    assign flt_data_out = flt_y;

    typedef struct packed {
        logic [16:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   res_cnt = 0;
    int   done_cnt = 0;
    int   flt_low_cnt = 0;
    int   cyc = 0;
    int   last_cyc = -100;
    logic [7:0] smp [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic push(input logic [16:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: counts events and scores every presented result.
    always @(negedge clk) begin
        if (reset_n) begin
            exp_t e;
            cyc++;
            if (!flt_reset_n) flt_low_cnt++;
            if (done) done_cnt++;
            if (m_valid) begin
                res_cnt++;
                if (m_last) last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_m_valid: got m_data 0x%0h, expected no result", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", {15'h0, m_data}, {15'h0, e.data});
                    check("m_last", {31'h0, m_last}, {31'h0, e.last});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
        num_samples = 16'h0000;
    endtask

    // Feed n samples from smp[]; a gap of gap_len RUN cycles before index gap_at;
    // an extra start pulse while sample poke_at is offered.
    task automatic feed(input int n, input int gap_at, input int gap_len, input int poke_at);
        int idx = 0;
        int gap_left = gap_len;
        int budget = 0;
        bit prev_gap = 1'b0;
        bit poked = 1'b0;
        while (idx < n && budget < 200) begin
            if (prev_gap) check("gap_zero_in", {24'h0, flt_data_in}, 32'h0);
            prev_gap = 1'b0;
            start = 1'b0;
            if (idx == poke_at && s_ready && !poked) begin
                start = 1'b1;
                num_samples = 16'd3;
                poked = 1'b1;
            end
            if (idx == gap_at && gap_left > 0 && s_ready) begin
                s_valid = 1'b0;
                s_data = 8'h55;
                gap_left--;
                prev_gap = 1'b1;
            end else begin
                s_valid = 1'b1;
                s_data = smp[idx];
                if (s_ready) idx++;
            end
            tick();
            budget++;
        end
        start = 1'b0;
        num_samples = 16'h0000;
        s_valid = 1'b0;
        s_data = 8'h00;
        if (idx < n) begin
            n_checks++;
            $display("FAIL feed_timeout: got %0d handshakes, expected %0d", idx, n);
        end
    endtask

    task automatic wait_done(input int dres, input int res0, input int done0, input int low0);
        int b = 0;
        while (!done && b < 200) begin
            tick();
            b++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout: got no done, expected done within 200 cycles");
        end
        check("busy_at_done", {31'h0, busy}, 32'h1);
        check("done_after_last", cyc - last_cyc, 32'h1);
        tick();
        check("done_one_cycle", {31'h0, done}, 32'h0);
        check("busy_after_done", {31'h0, busy}, 32'h0);
        check("result_count", res_cnt - res0, dres);
        check("done_count", done_cnt - done0, 32'h1);
        check("clear_cycles", flt_low_cnt - low0, 32'h2);
        check("queue_drained", exp_q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int r0, d0, l0;
        tick(); tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_s_ready", {31'h0, s_ready}, 32'h0);
        check("rst_flt_reset_n", {31'h0, flt_reset_n}, 32'h1);
        check("rst_m_valid", {31'h0, m_valid}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Job 1: four samples, source always valid.
        smp[0] = 8'h40; smp[1] = 8'hC0; smp[2] = 8'h20; smp[3] = 8'h00;
        push(17'h08000, 1'b0); push(17'h1C000, 1'b0); push(17'h02000, 1'b0); push(17'h01000, 1'b1);
        r0 = res_cnt; d0 = done_cnt; l0 = flt_low_cnt;
        do_start(16'd4);
        check("busy_after_start", {31'h0, busy}, 32'h1);
        check("clear_active", {31'h0, flt_reset_n}, 32'h0);
        feed(4, -1, 0, -1);
        wait_done(4, r0, d0, l0);
        check("underrun_clean", {31'h0, underrun}, 32'h0);

        // Job 2: three samples with a two-cycle starvation gap after the first.
        smp[0] = 8'h40; smp[1] = 8'h40; smp[2] = 8'h00;
        push(17'h08000, 1'b0); push(17'h09000, 1'b0); push(17'h04800, 1'b1);
        r0 = res_cnt; d0 = done_cnt; l0 = flt_low_cnt;
        do_start(16'd3);
        feed(3, 1, 2, -1);
        wait_done(3, r0, d0, l0);
        check("underrun_set", {31'h0, underrun}, 32'h1);

        // Zero-length job: immediate done, nothing else moves.
        r0 = res_cnt;
        do_start(16'd0);
        check("zero_done", {31'h0, done}, 32'h1);
        check("zero_busy", {31'h0, busy}, 32'h0);
        check("zero_s_ready", {31'h0, s_ready}, 32'h0);
        check("zero_flt_reset_n", {31'h0, flt_reset_n}, 32'h1);
        tick();
        check("zero_done_pulse", {31'h0, done}, 32'h0);
        check("underrun_sticky", {31'h0, underrun}, 32'h1);
        tick(); tick();
        check("zero_no_result", res_cnt - r0, 32'h0);

        // Job 3: five samples with an extra start pulse mid-RUN.
        for (int i = 0; i < 5; i++) smp[i] = 8'h40;
        push(17'h08000, 1'b0); push(17'h0C000, 1'b0); push(17'h0E000, 1'b0);
        push(17'h0F000, 1'b0); push(17'h0F800, 1'b1);
        r0 = res_cnt; d0 = done_cnt; l0 = flt_low_cnt;
        do_start(16'd5);
        feed(5, -1, 0, 2);
        wait_done(5, r0, d0, l0);
        check("underrun_cleared", {31'h0, underrun}, 32'h0);

        // Job 4: abort by reset after two of six samples.
        smp[0] = 8'h40; smp[1] = 8'h40;
        r0 = res_cnt; d0 = done_cnt;
        do_start(16'd6);
        feed(2, -1, 0, -1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_s_ready", {31'h0, s_ready}, 32'h0);
        check("abort_flt_reset_n", {31'h0, flt_reset_n}, 32'h1);
        check("abort_flt_data_in", {24'h0, flt_data_in}, 32'h0);
        check("abort_m_valid", {31'h0, m_valid}, 32'h0);
        check("abort_m_data", {15'h0, m_data}, 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        check("abort_no_done", done_cnt - d0, 32'h0);
        check("abort_no_result", res_cnt - r0, 32'h0);

        // Job 5: two samples after the abort; CLEAR must wipe stale filter state.
        smp[0] = 8'h20; smp[1] = 8'h20;
        push(17'h04000, 1'b0); push(17'h06000, 1'b1);
        r0 = res_cnt; d0 = done_cnt; l0 = flt_low_cnt;
        do_start(16'd2);
        feed(2, -1, 0, -1);
        wait_done(2, r0, d0, l0);

        // Jobs 6 and 7: back-to-back single-sample jobs.
        smp[0] = 8'hC0;
        push(17'h18000, 1'b1);
        r0 = res_cnt; d0 = done_cnt; l0 = flt_low_cnt;
        do_start(16'd1);
        feed(1, -1, 0, -1);
        wait_done(1, r0, d0, l0);
        smp[0] = 8'h20;
        push(17'h04000, 1'b1);
        r0 = res_cnt; d0 = done_cnt; l0 = flt_low_cnt;
        do_start(16'd1);
        feed(1, -1, 0, -1);
        wait_done(1, r0, d0, l0);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
